// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: memory-mapped multi-bank 7-segment scan controller with blink, raw mode and match IRQ
module led_scan_ctrl #(
    parameter int BANKS     = 2,
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:2]           addr,
    input  logic                 we,
    input  logic [31:0]          DEV_WD,
    output logic [31:0]          DEV_RD,
    output logic [DIGITS-1:0]    led_sel,
    output logic [8*BANKS-1:0]   led_signal,
    output logic                 irq
);
    localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [15:0][7:0] HEX = {8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
                                        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC};

    logic [31:0] preset, current, ctrl, mask, raw0, raw1;
    logic [63:0] raw_all;
    logic [7:0] blank, dp, blink;
    logic match, phase, phase_nxt, tick, wrap, blink_wrap, en, clr;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [SW-1:0] slot, slot_nxt;
    logic [BW-1:0] blink_cnt, blink_nxt;
    logic [15:0] frame_cnt;
    logic [8*BANKS-1:0] seg_nxt;
    logic [2:0] g;
    logic [7:0] s;

    assign en = ctrl[0];
    assign raw_all = {raw1, raw0};
    assign {blink, dp, blank} = mask[23:0];
    assign clr = we && addr == 3'd6 && DEV_WD[0];
    assign irq = match && ctrl[3];

    assign tick = en && div_cnt == DW'(SCAN_DIV - 1);
    assign wrap = tick && slot == SW'(DIGITS - 1);
    assign blink_wrap = wrap && blink_cnt == BW'(BLINK_DIV - 1);
    assign div_nxt = (!en || tick) ? '0 : div_cnt + DW'(1);
    assign slot_nxt = (!en || wrap) ? '0 : tick ? slot + SW'(1) : slot;
    assign blink_nxt = (!en || blink_wrap) ? '0 : wrap ? blink_cnt + BW'(1) : blink_cnt;
    assign phase_nxt = en && (phase ^ blink_wrap);

    // Segments are built from the next slot so select and data land on the same edge
    always_comb begin
        seg_nxt = '0;
        g = '0;
        s = '0;
        for (int b = 0; b < BANKS; b++) begin
            g = 3'(b * DIGITS) + 3'(slot_nxt);
            s = ctrl[1] ? raw_all[8*g +: 8] : HEX[current[4*g +: 4]];
            s[0] = s[0] | dp[g];
            seg_nxt[8*b +: 8] = (blank[g] || (ctrl[2] && phase_nxt && blink[g])) ? 8'h00 : s;
        end
    end

    always_comb begin
        case (addr)
            3'd0: DEV_RD = preset;
            3'd1: DEV_RD = current;
            3'd2: DEV_RD = ctrl;
            3'd3: DEV_RD = mask;
            3'd4: DEV_RD = raw0;
            3'd5: DEV_RD = raw1;
            3'd6: DEV_RD = {frame_cnt, 8'(slot), 7'b0, match};
            default: DEV_RD = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            preset     <= '0;
            current    <= '0;
            ctrl       <= 32'h1;
            mask       <= '0;
            raw0       <= '0;
            raw1       <= '0;
            match      <= 1'b0;
            div_cnt    <= '0;
            slot       <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            frame_cnt  <= '0;
            led_sel    <= DIGITS'(1);
            led_signal <= {BANKS{8'hFC}};
        end else begin
            if (we) begin
                case (addr)
                    3'd0: preset <= DEV_WD;
                    3'd1: current <= DEV_WD;
                    3'd2: ctrl <= DEV_WD;
                    3'd3: mask <= DEV_WD;
                    3'd4: raw0 <= DEV_WD;
                    3'd5: raw1 <= DEV_WD;
                    default: ;
                endcase
            end
            // A true compare wins over a same-cycle clear
            match      <= (current == preset) || (match && !clr);
            div_cnt    <= div_nxt;
            slot       <= slot_nxt;
            blink_cnt  <= blink_nxt;
            phase      <= phase_nxt;
            frame_cnt  <= wrap ? frame_cnt + 16'd1 : frame_cnt;
            led_sel    <= en ? DIGITS'(1) << slot_nxt : '0;
            led_signal <= en ? seg_nxt : '0;
        end
    end
endmodule
